// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: registers one instruction from MEM, retires it, and is the
// single point where exceptions and ERTN raise a pipeline flush with a redirect target.
module wb_commit_stage #(
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int ECODE_W = 6,
    parameter int CNT_W   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 me_valid,
    output logic                 wb_allow_in,
    input  logic [XLEN-1:0]      me_pc,
    input  logic                 me_gr_we,
    input  logic [RF_AW-1:0]     me_dest,
    input  logic [XLEN-1:0]      me_result,
    input  logic                 me_excp,
    input  logic [ECODE_W-1:0]   me_ecode,
    input  logic [XLEN-1:0]      me_badv,
    input  logic                 me_ertn,
    input  logic                 wb_hold,
    input  logic [XLEN-1:0]      csr_eentry,
    input  logic [XLEN-1:0]      csr_era,
    output logic                 rf_we,
    output logic [RF_AW-1:0]     rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_fwd_valid,
    output logic [RF_AW-1:0]     wb_fwd_dest,
    output logic                 flush,
    output logic [XLEN-1:0]      flush_target,
    output logic                 excp_commit,
    output logic [ECODE_W-1:0]   excp_ecode,
    output logic [XLEN-1:0]      excp_pc,
    output logic [XLEN-1:0]      excp_badv,
    output logic                 ertn_commit,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [XLEN-1:0]      debug_wb_pc,
    output logic [XLEN/8-1:0]    debug_wb_rf_we,
    output logic [RF_AW-1:0]     debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic               gr_we;
        logic [RF_AW-1:0]   dest;
        logic [XLEN-1:0]    result;
        logic               excp;
        logic [ECODE_W-1:0] ecode;
        logic [XLEN-1:0]    badv;
        logic               ertn;
    } payload_t;

    logic             v_q, v_d;
    payload_t         pl_q, pl_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic ready_go;
    logic commit;
    logic flush_int;

    always_comb begin
        ready_go    = !wb_hold;
        wb_allow_in = !v_q || ready_go;
        commit      = v_q && ready_go;
        flush_int   = commit && (pl_q.excp || pl_q.ertn);
    end

    // NOTE: every signal written in this block gets a default first, so no latch is inferred.
    always_comb begin
        v_d          = v_q;
        pl_d         = pl_q;
        retire_cnt_d = retire_cnt_q;
        if (wb_allow_in) begin
            v_d = me_valid && !flush_int;
        end
        // An instruction arriving in the flush cycle is younger than the trap and is dropped.
        if (me_valid && wb_allow_in && !flush_int) begin
            pl_d.pc     = me_pc;
            pl_d.gr_we  = me_gr_we;
            pl_d.dest   = me_dest;
            pl_d.result = me_result;
            pl_d.excp   = me_excp;
            pl_d.ecode  = me_ecode;
            pl_d.badv   = me_badv;
            pl_d.ertn   = me_ertn;
        end
        if (commit && !pl_q.excp) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and also
    // clears the payload so every trace output reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q          <= 1'b0;
            pl_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            v_q          <= v_d;
            pl_q         <= pl_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        rf_we        = commit && pl_q.gr_we && !pl_q.excp;
        rf_waddr     = pl_q.dest;
        rf_wdata     = pl_q.result;

        wb_fwd_valid = v_q && pl_q.gr_we && !pl_q.excp && (pl_q.dest != '0);
        wb_fwd_dest  = wb_fwd_valid ? pl_q.dest : '0;

        flush        = flush_int;
        flush_target = '0;
        if (flush_int) begin
            flush_target = pl_q.excp ? csr_eentry : csr_era;
        end

        excp_commit  = commit && pl_q.excp;
        excp_ecode   = excp_commit ? pl_q.ecode : '0;
        excp_pc      = excp_commit ? pl_q.pc    : '0;
        excp_badv    = excp_commit ? pl_q.badv  : '0;
        ertn_commit  = commit && pl_q.ertn && !pl_q.excp;

        retire_cnt        = retire_cnt_q;
        debug_wb_pc       = pl_q.pc;
        debug_wb_rf_we    = {(XLEN/8){rf_we}};
        debug_wb_rf_wnum  = pl_q.dest;
        debug_wb_rf_wdata = pl_q.result;
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed scenarios plus random traffic, all checked
// against a one-slot behavioural model of the stage.
module tb_wb_commit_stage;

    localparam int XLEN    = 32;
    localparam int RF_AW   = 5;
    localparam int ECODE_W = 6;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, me_valid, me_gr_we, me_excp, me_ertn, wb_hold;
    logic [XLEN-1:0]      me_pc, me_result, me_badv, csr_eentry, csr_era;
    logic [RF_AW-1:0]     me_dest;
    logic [ECODE_W-1:0]   me_ecode;
    logic                 wb_allow_in, rf_we, wb_fwd_valid, flush, excp_commit, ertn_commit;
    logic [RF_AW-1:0]     rf_waddr, wb_fwd_dest, debug_wb_rf_wnum;
    logic [XLEN-1:0]      rf_wdata, flush_target, excp_pc, excp_badv, debug_wb_pc, debug_wb_rf_wdata;
    logic [ECODE_W-1:0]   excp_ecode;
    logic [CNT_W-1:0]     retire_cnt;
    logic [XLEN/8-1:0]    debug_wb_rf_we;

    wb_commit_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .ECODE_W(ECODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .me_valid(me_valid), .wb_allow_in(wb_allow_in),
        .me_pc(me_pc), .me_gr_we(me_gr_we), .me_dest(me_dest), .me_result(me_result),
        .me_excp(me_excp), .me_ecode(me_ecode), .me_badv(me_badv), .me_ertn(me_ertn),
        .wb_hold(wb_hold), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_dest(wb_fwd_dest),
        .flush(flush), .flush_target(flush_target), .excp_commit(excp_commit),
        .excp_ecode(excp_ecode), .excp_pc(excp_pc), .excp_badv(excp_badv),
        .ertn_commit(ertn_commit), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct packed {
        logic               reset;
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic               gr_we;
        logic [RF_AW-1:0]   dest;
        logic [XLEN-1:0]    result;
        logic               excp;
        logic [ECODE_W-1:0] ecode;
        logic [XLEN-1:0]    badv;
        logic               ertn;
        logic               hold;
        logic [XLEN-1:0]    eentry;
        logic [XLEN-1:0]    era;
    } stim_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which instruction (if any) sits in WB, and how many have retired.
    logic        m_v;
    stim_t       m_inst;
    logic [63:0] m_retired;

    // Observations of the most recent step, for the directed scenario checks.
    logic        o_rf_we, o_flush, o_ertn, o_allow, o_fwd_v, o_nonzero;
    logic [XLEN-1:0]  o_target, o_excp_pc;
    logic [RF_AW-1:0] o_fwd_d;
    logic [CNT_W-1:0] o_cnt;
    logic [XLEN/8-1:0] o_dbg_we;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s        = '0;
        s.eentry = 32'h1c00_8000;
        s.era    = 32'h1c00_0040;
        return s;
    endfunction

    function automatic stim_t inst(input logic [XLEN-1:0] pc, input logic [RF_AW-1:0] dest);
        stim_t s;
        s        = idle();
        s.valid  = 1'b1;
        s.pc     = pc;
        s.gr_we  = 1'b1;
        s.dest   = dest;
        s.result = $urandom;
        s.badv   = $urandom;
        s.ecode  = ECODE_W'($urandom);
        return s;
    endfunction

    task automatic step(input stim_t s);
        logic commit, fl, rfw, ex, fwd;
        @(negedge clk);
        reset = s.reset;      me_valid = s.valid;   me_pc = s.pc;       me_gr_we = s.gr_we;
        me_dest = s.dest;     me_result = s.result; me_excp = s.excp;   me_ecode = s.ecode;
        me_badv = s.badv;     me_ertn = s.ertn;     wb_hold = s.hold;
        csr_eentry = s.eentry; csr_era = s.era;
        #1;
        commit = m_v && !s.hold;
        ex     = commit && m_inst.excp;
        fl     = commit && (m_inst.excp || m_inst.ertn);
        rfw    = commit && m_inst.gr_we && !m_inst.excp;
        fwd    = m_v && m_inst.gr_we && !m_inst.excp && (m_inst.dest != 0);
        check("allow_in", wb_allow_in, !m_v || !s.hold);
        check("rf_we", rf_we, rfw);
        if (rfw) begin
            check("rf_waddr", rf_waddr, m_inst.dest);
            check("rf_wdata", rf_wdata, m_inst.result);
        end
        check("flush", flush, fl);
        if (fl) check("flush_target", flush_target, m_inst.excp ? s.eentry : s.era);
        check("excp_commit", excp_commit, ex);
        if (ex) begin
            check("excp_ecode", excp_ecode, m_inst.ecode);
            check("excp_pc", excp_pc, m_inst.pc);
            check("excp_badv", excp_badv, m_inst.badv);
        end
        check("ertn_commit", ertn_commit, commit && m_inst.ertn && !m_inst.excp);
        check("fwd_valid", wb_fwd_valid, fwd);
        check("fwd_dest", wb_fwd_dest, fwd ? m_inst.dest : 0);
        check("retire_cnt", retire_cnt, m_retired % (64'd1 << CNT_W));
        check("dbg_pc", debug_wb_pc, m_inst.pc);
        check("dbg_we", debug_wb_rf_we, rfw ? 4'hf : 4'h0);
        check("dbg_wnum", debug_wb_rf_wnum, m_inst.dest);
        check("dbg_wdata", debug_wb_rf_wdata, m_inst.result);
        o_rf_we = rf_we;  o_flush = flush;  o_ertn = ertn_commit;  o_allow = wb_allow_in;
        o_fwd_v = wb_fwd_valid;  o_fwd_d = wb_fwd_dest;  o_cnt = retire_cnt;
        o_target = flush_target;  o_excp_pc = excp_pc;  o_dbg_we = debug_wb_rf_we;
        o_nonzero = rf_we | (|rf_waddr) | (|rf_wdata) | wb_fwd_valid | (|wb_fwd_dest) | flush |
                    (|flush_target) | excp_commit | (|excp_ecode) | (|excp_pc) | (|excp_badv) |
                    ertn_commit | (|retire_cnt) | (|debug_wb_pc) | (|debug_wb_rf_we) |
                    (|debug_wb_rf_wnum) | (|debug_wb_rf_wdata);
        @(posedge clk);
        if (s.reset) begin
            m_v       = 1'b0;
            m_inst    = '0;
            m_retired = '0;
        end else begin
            if (commit && !m_inst.excp) m_retired++;
            if (!m_v || !s.hold) begin
                m_v = s.valid && !fl;
                if (s.valid && !fl) m_inst = s;
            end
        end
    endtask

    initial begin
        stim_t s;
        int pulses, zeros;
        logic [CNT_W-1:0] cnt0;

        reset = 1'b1; me_valid = 0; me_pc = 0; me_gr_we = 0; me_dest = 0; me_result = 0;
        me_excp = 0; me_ecode = 0; me_badv = 0; me_ertn = 0; wb_hold = 0;
        csr_eentry = 0; csr_era = 0;
        m_v = 1'b0; m_inst = '0; m_retired = '0;
        repeat (2) @(posedge clk);

        // Reset state, then four back-to-back writes.
        s = idle(); s.reset = 1'b1; step(s);
        check("reset_outputs_zero", o_nonzero, 0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step(inst(32'h1c00_0000 + 32'(4 * k), RF_AW'(k + 1)));
            pulses += int'(o_rf_we);
        end
        step(idle());
        pulses += int'(o_rf_we);
        check("b2b_pulses", pulses, 4);
        check("b2b_dbg_we", o_dbg_we, 4'hf);
        step(idle());
        check("b2b_cnt", o_cnt, 4);

        // Hold for three cycles with a younger instruction waiting.
        step(inst(32'h1c00_0100, 5'd9));
        cnt0 = o_cnt; pulses = 0; zeros = 0;
        for (int k = 0; k < 3; k++) begin
            s = inst(32'h1c00_0104, 5'd10); s.hold = 1'b1; step(s);
            pulses += int'(o_rf_we); zeros += int'(!o_allow);
        end
        step(inst(32'h1c00_0104, 5'd10));
        pulses += int'(o_rf_we);
        check("hold_pulses", pulses, 1);
        check("hold_allow_low", zeros, 3);
        step(idle());
        step(idle());
        check("hold_cnt", o_cnt, cnt0 + 4'd2);

        // Exception flushes the following instruction; counter unchanged.
        cnt0 = o_cnt;
        s = inst(32'h1c00_0200, 5'd3); s.excp = 1'b1; s.ecode = 6'h0b; step(s);
        step(inst(32'h1c00_0204, 5'd5));
        check("excp_flush", o_flush, 1);
        check("excp_target", o_target, 32'h1c00_8000);
        check("excp_pc_seen", o_excp_pc, 32'h1c00_0200);
        check("excp_no_write", o_rf_we, 0);
        step(idle());
        check("excp_discard_fwd", o_fwd_v, 0);
        check("excp_discard_we", o_rf_we, 0);
        check("excp_cnt", o_cnt, cnt0);

        // ERTN retires and redirects to ERA.
        s = inst(32'h1c00_0300, 5'd0); s.gr_we = 1'b0; s.ertn = 1'b1; step(s);
        step(idle());
        check("ertn_flush", o_flush, 1);
        check("ertn_commit", o_ertn, 1);
        check("ertn_target", o_target, 32'h1c00_0040);
        step(idle());
        check("ertn_cnt", o_cnt, cnt0 + 4'd1);

        // Forwarding tag: r0 never forwards.
        step(inst(32'h1c00_0400, 5'd0));
        step(inst(32'h1c00_0404, 5'd7));
        check("fwd_r0", o_fwd_v, 0);
        s = idle(); s.hold = 1'b1; step(s);
        check("fwd_r7_valid", o_fwd_v, 1);
        check("fwd_r7_dest", o_fwd_d, 7);
        step(idle());

        // 17 commits wrap a 4-bit counter to 1.
        s = idle(); s.reset = 1'b1; step(s);
        for (int k = 0; k < 17; k++) step(inst(32'h1c00_1000 + 32'(4 * k), RF_AW'(k)));
        step(idle());
        step(idle());
        check("wrap_cnt", o_cnt, 1);

        // Reset asserted while an instruction is held.
        step(inst(32'h1c00_2000, 5'd4));
        s = idle(); s.hold = 1'b1; step(s);
        s.reset = 1'b1; step(s);
        step(idle());
        check("midhold_reset_zero", o_nonzero, 0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            s        = inst($urandom, RF_AW'($urandom));
            s.valid  = ($urandom_range(0, 3) != 0);
            s.gr_we  = ($urandom_range(0, 3) != 0);
            s.excp   = ($urandom_range(0, 7) == 0);
            s.ertn   = ($urandom_range(0, 7) == 0);
            s.hold   = ($urandom_range(0, 2) == 0);
            s.reset  = ($urandom_range(0, 63) == 0);
            s.eentry = $urandom;
            s.era    = $urandom;
            step(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised writeback/commit stage for the five-stage in-order pipeline, sitting between the memory stage and the register file. It registers one instruction per cycle behind a valid/allow-in handshake and retires it. It is the single point where exceptions and ERTN are committed: it raises a flush with a redirect target. It also supports an external hold, exposes a forwarding tag, keeps a retire counter, and drives the debug trace.

## Interface
- XLEN, 32, datapath and PC width; must be a multiple of 8
- RF_AW, 5, register-file address width
- ECODE_W, 6, exception code width
- CNT_W, 64, retire counter width

Clock and reset: reset is synchronous, active-high; clock is clk.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- me_valid  in  1  memory stage offers an instruction
- wb_allow_in  out  1  stage can accept this cycle
- me_pc  in  XLEN  instruction PC
- me_gr_we  in  1  instruction writes the register file
- me_dest  in  RF_AW  destination register
- me_result  in  XLEN  final result
- me_excp  in  1  instruction carries an exception
- me_ecode  in  ECODE_W  exception code
- me_badv  in  XLEN  bad virtual address
- me_ertn  in  1  instruction is ERTN
- wb_hold  in  1  external stall (e.g. CSR side effect pending)
- csr_eentry  in  XLEN  exception entry address
- csr_era  in  XLEN  exception return address
- rf_we  out  1  register-file write strobe
- rf_waddr  out  RF_AW  write address
- rf_wdata  out  XLEN  write data
- wb_fwd_valid  out  1  WB holds a live register write (dest≠0)
- wb_fwd_dest  out  RF_AW  dest when wb_fwd_valid, else 0
- flush  out  1  pipeline flush pulse
- flush_target  out  XLEN  redirect PC
- excp_commit  out  1  exception committed this cycle
- excp_ecode  out  ECODE_W  committed ecode
- excp_pc  out  XLEN  committed PC (to ERA)
- excp_badv  out  XLEN  committed BADV
- ertn_commit  out  1  ERTN committed this cycle
- retire_cnt  out  CNT_W  retired instruction count
- debug_wb_pc  out  XLEN  trace PC
- debug_wb_rf_we  out  XLEN/8  trace write enable, replicated
- debug_wb_rf_wnum  out  RF_AW  trace dest
- debug_wb_rf_wdata  out  XLEN  trace data

## Operation
- Stage valid bit `v` and payload registers. ready_go = !wb_hold. wb_allow_in = !v || ready_go.
- commit = v && ready_go. An instruction commits exactly once, in its final WB cycle; held cycles never commit.
- Load: when wb_allow_in is 1, v <= me_valid && !flush. The payload loads only when me_valid && wb_allow_in && !flush. If flush is 1 in the same cycle, the incoming instruction is discarded.
- rf_we = commit && gr_we && !excp. A write to r0 still strobes; the register file ignores it.
- Exception: excp_commit = commit && excp. flush = commit && (excp || ertn). flush_target = csr_eentry when excp, csr_era when ertn; excp takes priority if both are set.
- ertn_commit = commit && ertn && !excp.
- Forwarding: wb_fwd_valid = v && gr_we && !excp && dest≠0. It is independent of hold.
- Retire counter: increments by 1 on each commit with !excp, including ERTN. It wraps modulo 2^CNT_W.
- Debug: debug_wb_rf_we = {XLEN/8{rf_we}}. pc, dest and result are driven straight from the payload registers.

## Timing
- Reset: v=0 and all payload registers 0, so every output is 0. retire_cnt=0.
- Latency: 1 cycle from accept (rising edge) to commit outputs. All outputs are combinational from the stage registers, wb_hold and the CSR inputs.
- Hold: while wb_hold=1 and v=1, the payload is frozen, wb_allow_in=0 and commit outputs are 0. Commit occurs in the first cycle wb_hold=0.
- Back-to-back: with wb_hold=0, one instruction commits per cycle at full throughput.
- Flush cycle: flush is a single-cycle pulse; the next cycle has v=0.
- Reset mid-hold or mid-flush: state clears at the next edge with no commit.

## Test plan
- Reset, then 4 back-to-back instructions (pc 0x1c000000+4k, dest 1..4, gr_we=1) -> rf_we=1 on 4 consecutive cycles; retire_cnt=4; debug_wb_rf_we=4'hf.
- Hold 3 cycles with an instruction in WB -> wb_allow_in=0 and rf_we=0 for 3 cycles; exactly one rf_we pulse after release; retire_cnt += 1.
- Exception (me_excp=1, ecode 0x0b, csr_eentry=0x1c008000) followed by a valid instruction -> rf_we=0, flush=1, flush_target=0x1c008000, excp_pc=inst pc; the next instruction is discarded (v=0 next cycle); retire_cnt unchanged.
- ERTN with csr_era=0x1c000040 -> flush=1, ertn_commit=1, flush_target=0x1c000040, retire_cnt += 1.
- Forwarding: dest=0 with gr_we=1 -> wb_fwd_valid=0; dest=7 -> wb_fwd_valid=1, wb_fwd_dest=7.
- Counter wrap with CNT_W=4: 17 commits -> retire_cnt=1; reset asserted mid-hold -> all outputs 0 next cycle.
